// File: rtl/ten_eth_seek_arb.sv
// ten_eth_seek_arb
// Round-robin arbiter in front of a single MAC-to-outport lookup engine.
// Each rx port posts a one-cycle request (dst MAC + id); the arbiter grants
// one pending port, classifies the destination and strobes the result back
// to the requesting port. One lookup takes three cycles (IDLE/RESOLVE/RESP).
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_check_mac            48 bits per port, slice p = [48p+47:48p]
//   i_check_id             4 bits per port, request id
//   i_check_valid          per-port single-cycle request pulse
//   i_cur_connect_tor      ToR currently reachable over the optical uplink
//   o_outport              resolved outport (held until next result)
//   o_seek_flag            route class: 00 local, 01 uplink, 10 DDR queue, 11 drop
//   o_check_id             id of the answered request
//   o_result_valid         one-hot result strobe to the requesting port
//   o_stat_lookup_cnt      saturating count of answered lookups
//   o_stat_ovwr_cnt        saturating count of requests overwritten while pending
//
// Build option: define TEN_ETH_SEEK_ARB_STAT_EN to include the statistics
// counters; otherwise both statistics outputs are tied to 0.
//
// state    | meaning
// S_IDLE   | wait for a pending port, grant it round-robin
// S_RESOLVE| classify the granted MAC, register the result
// S_RESP   | result strobe high, advance round-robin pointer
module ten_eth_seek_arb #(
   parameter int          P_PORT_NUM    = 4,
   parameter logic [31:0] P_MAC_HEAD    = 32'h8D_BC_5C_4A,
   parameter logic [2:0]  P_MY_TOR_ID   = 3'd0,
   parameter logic [2:0]  P_UPLINK_PORT = 3'd7
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [48*P_PORT_NUM-1:0] i_check_mac,
   input  logic [4*P_PORT_NUM-1:0] i_check_id,
   input  logic [P_PORT_NUM-1:0]   i_check_valid,
   input  logic [2:0]              i_cur_connect_tor,
   output logic [2:0]              o_outport,
   output logic [1:0]              o_seek_flag,
   output logic [3:0]              o_check_id,
   output logic [P_PORT_NUM-1:0]   o_result_valid,
   output logic [31:0]             o_stat_lookup_cnt,
   output logic [15:0]             o_stat_ovwr_cnt
);

   localparam int IW = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [P_PORT_NUM-1:0]   pending_q, pending_d;
   logic [47:0]             mac_q [P_PORT_NUM];
   logic [3:0]              id_q  [P_PORT_NUM];
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]           gnt_q, gnt_d;
   logic [47:0]             gmac_q, gmac_d;
   logic [3:0]              gid_q, gid_d;
   logic [2:0]              outport_q, outport_d;
   logic [1:0]              flag_q, flag_d;
   logic [3:0]              cid_q, cid_d;
   logic [P_PORT_NUM-1:0]   rv_q, rv_d;

   logic                    found;
   logic [IW-1:0]           sel;
   logic [2:0]              cls_out;
   logic [1:0]              cls_flag;

   wire  [31:0]             head = gmac_q[47:16];
   wire  [7:0]              tor  = gmac_q[15:8];
   wire  [7:0]              prt  = gmac_q[7:0];

   // First pending port at or after rr_ptr, wrapping at P_PORT_NUM-1.
   always_comb begin
      int j;
      found = 1'b0;
      sel   = '0;
      j     = 0;
      for (int i = 0; i < P_PORT_NUM; i++) begin
         j = int'(rr_ptr_q) + i;
         if (j >= P_PORT_NUM) j = j - P_PORT_NUM;
         if (!found && pending_q[j]) begin
            found = 1'b1;
            sel   = IW'(j);
         end
      end
   end

   // Anything not matching the head, or naming a ToR beyond 3 bits, is dropped.
   always_comb begin
      cls_flag = 2'b11;
      cls_out  = 3'd0;
      if (head == P_MAC_HEAD && tor[7:3] == 5'd0) begin
         if (tor[2:0] == P_MY_TOR_ID) begin
            if (prt != 8'd0) begin
               cls_flag = 2'b00;
               cls_out  = prt[2:0] - 3'd1;
            end
         end else if (tor[2:0] == i_cur_connect_tor) begin
            cls_flag = 2'b01;
            cls_out  = P_UPLINK_PORT;
         end else begin
            cls_flag = 2'b10;
            cls_out  = tor[2:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      gmac_d    = gmac_q;
      gid_d     = gid_q;
      outport_d = outport_q;
      flag_d    = flag_q;
      cid_d     = cid_q;
      rv_d      = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               pending_d[sel] = 1'b0;
               gnt_d          = sel;
               gmac_d         = mac_q[sel];
               gid_d          = id_q[sel];
               state_d        = S_RESOLVE;
            end
         end
         S_RESOLVE: begin
            outport_d   = cls_out;
            flag_d      = cls_flag;
            cid_d       = gid_q;
            rv_d[gnt_q] = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            rr_ptr_d = (int'(gnt_q) == P_PORT_NUM - 1) ? '0 : gnt_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Applied after the grant clear so a pulse in the grant cycle stays pending.
      pending_d = pending_d | i_check_valid;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         gmac_q    <= '0;
         gid_q     <= '0;
         outport_q <= '0;
         flag_q    <= '0;
         cid_q     <= '0;
         rv_q      <= '0;
         for (int p = 0; p < P_PORT_NUM; p++) begin
            mac_q[p] <= '0;
            id_q[p]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         gmac_q    <= gmac_d;
         gid_q     <= gid_d;
         outport_q <= outport_d;
         flag_q    <= flag_d;
         cid_q     <= cid_d;
         rv_q      <= rv_d;
         for (int p = 0; p < P_PORT_NUM; p++) begin
            if (i_check_valid[p]) begin
               mac_q[p] <= i_check_mac[48*p +: 48];
               id_q[p]  <= i_check_id[4*p +: 4];
            end
         end
      end
   end

   assign o_outport      = outport_q;
   assign o_seek_flag    = flag_q;
   assign o_check_id     = cid_q;
   assign o_result_valid = rv_q;

`ifdef TEN_ETH_SEEK_ARB_STAT_EN
   logic [31:0]           lookup_cnt_q;
   logic [15:0]           ovwr_cnt_q;
   logic [P_PORT_NUM-1:0] gclr;
   logic [P_PORT_NUM-1:0] ovwr_evt;
   logic [3:0]            ovwr_num;
   logic [16:0]           ovwr_sum;

   // A pulse landing on the port being granted starts a fresh request rather
   // than replacing one still waiting, so it is not an overwrite.
   always_comb begin
      gclr = '0;
      if (state_q == S_IDLE && found) gclr[sel] = 1'b1;
      ovwr_evt = i_check_valid & pending_q & ~gclr;
      ovwr_num = '0;
      for (int p = 0; p < P_PORT_NUM; p++) ovwr_num = ovwr_num + {3'b000, ovwr_evt[p]};
      ovwr_sum = {1'b0, ovwr_cnt_q} + {13'd0, ovwr_num};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lookup_cnt_q <= '0;
         ovwr_cnt_q   <= '0;
      end else begin
         if (state_q == S_RESP && lookup_cnt_q != '1) lookup_cnt_q <= lookup_cnt_q + 32'd1;
         ovwr_cnt_q <= ovwr_sum[16] ? '1 : ovwr_sum[15:0];
      end
   end

   assign o_stat_lookup_cnt = lookup_cnt_q;
   assign o_stat_ovwr_cnt   = ovwr_cnt_q;
`else
   assign o_stat_lookup_cnt = 32'd0;
   assign o_stat_ovwr_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_ten_eth_seek_arb.sv
module tb_ten_eth_seek_arb;

   localparam int P = 4;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic [48*P-1:0] i_check_mac;
   logic [4*P-1:0]  i_check_id;
   logic [P-1:0]    i_check_valid;
   logic [2:0]      i_cur_connect_tor;
   logic [2:0]      o_outport;
   logic [1:0]      o_seek_flag;
   logic [3:0]      o_check_id;
   logic [P-1:0]    o_result_valid;
   logic [31:0]     o_stat_lookup_cnt;
   logic [15:0]     o_stat_ovwr_cnt;

   ten_eth_seek_arb #(.P_PORT_NUM(P)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_check_mac       (i_check_mac),
      .i_check_id        (i_check_id),
      .i_check_valid     (i_check_valid),
      .i_cur_connect_tor (i_cur_connect_tor),
      .o_outport         (o_outport),
      .o_seek_flag       (o_seek_flag),
      .o_check_id        (o_check_id),
      .o_result_valid    (o_result_valid),
      .o_stat_lookup_cnt (o_stat_lookup_cnt),
      .o_stat_ovwr_cnt   (o_stat_ovwr_cnt)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_lk  = 0;

`ifdef TEN_ETH_SEEK_ARB_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   typedef struct {
      int          port;
      logic [47:0] mac;
      logic [2:0]  cur;
      logic [3:0]  id;
      logic [2:0]  exp_out;
      logic [1:0]  exp_flag;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [47:0] mac, input logic [3:0] id);
      i_check_valid[p]        = 1'b1;
      i_check_mac[48*p +: 48] = mac;
      i_check_id[4*p +: 4]    = id;
   endtask

   task automatic strobe(input string nm, input int p, input logic [2:0] out,
                         input logic [1:0] flag, input logic [3:0] id);
      logic [P-1:0] oh;
      oh    = '0;
      oh[p] = 1'b1;
      exp_lk++;
      chk({nm, "_valid"}, 64'(o_result_valid), 64'(oh));
      chk({nm, "_outport"}, 64'(o_outport), 64'(out));
      chk({nm, "_flag"}, 64'(o_seek_flag), 64'(flag));
      chk({nm, "_id"}, 64'(o_check_id), 64'(id));
   endtask

   task automatic quiet(input string nm);
      chk({nm, "_quiet"}, 64'(o_result_valid), 64'd0);
   endtask

   localparam logic [47:0] MAC_LOCAL2 = 48'h8DBC5C4A_00_02;

   initial begin
      vecs[0] = '{1, 48'h8DBC5C4A_00_02, 3'd3, 4'h1, 3'd1, 2'b00};
      vecs[1] = '{0, 48'h8DBC5C4A_03_01, 3'd3, 4'h2, 3'd7, 2'b01};
      vecs[2] = '{2, 48'h8DBC5C4A_05_01, 3'd3, 4'h3, 3'd5, 2'b10};
      vecs[3] = '{3, 48'h12345678_00_02, 3'd3, 4'h4, 3'd0, 2'b11};
      vecs[4] = '{1, 48'h8DBC5C4A_00_00, 3'd3, 4'h5, 3'd0, 2'b11};
      vecs[5] = '{2, 48'h8DBC5C4A_08_01, 3'd3, 4'h6, 3'd0, 2'b11};
      vecs[6] = '{0, 48'h8DBC5C4A_00_05, 3'd0, 4'h7, 3'd4, 2'b00};
      vecs[7] = '{3, 48'h8DBC5C4A_07_01, 3'd7, 4'h8, 3'd7, 2'b01};

      i_rst             = 1'b1;
      i_check_mac       = '0;
      i_check_id        = '0;
      i_check_valid     = '0;
      i_cur_connect_tor = 3'd0;
      tick; tick; tick;
      chk("rst_valid", 64'(o_result_valid), 64'd0);
      chk("rst_outport", 64'(o_outport), 64'd0);
      chk("rst_flag", 64'(o_seek_flag), 64'd0);
      chk("rst_id", 64'(o_check_id), 64'd0);
      chk("rst_lookup", 64'(o_stat_lookup_cnt), 64'd0);
      chk("rst_ovwr", 64'(o_stat_ovwr_cnt), 64'd0);
      i_rst = 1'b0;
      tick;

      // Single requests through every route class; result lands at n+3.
      for (int v = 0; v < 8; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         i_cur_connect_tor = vecs[v].cur;
         set_req(vecs[v].port, vecs[v].mac, vecs[v].id);
         tick; i_check_valid = '0;
         quiet({nm, "_n1"});
         tick; quiet({nm, "_n2"});
         tick; strobe(nm, vecs[v].port, vecs[v].exp_out, vecs[v].exp_flag, vecs[v].id);
         tick; quiet({nm, "_n4"});
         chk({nm, "_hold"}, 64'(o_outport), 64'(vecs[v].exp_out));
      end

      // Fairness from rr_ptr 0 (last grant was port 3).
      for (int p = 0; p < P; p++) set_req(p, MAC_LOCAL2, 4'(p + 1));
      tick; i_check_valid = '0;
      tick; tick; strobe("rr0_p0", 0, 3'd1, 2'b00, 4'd1);
      for (int k = 1; k < P; k++) begin
         tick; quiet("rr0_gap");
         tick; quiet("rr0_gap");
         tick; strobe($sformatf("rr0_p%0d", k), k, 3'd1, 2'b00, 4'(k + 1));
      end
      tick;

      // Move rr_ptr to 2 with a single request on port 1.
      set_req(1, MAC_LOCAL2, 4'hA);
      tick; i_check_valid = '0;
      tick; tick; strobe("rr_move", 1, 3'd1, 2'b00, 4'hA);
      tick;
      for (int p = 0; p < P; p++) set_req(p, MAC_LOCAL2, 4'(p + 8));
      tick; i_check_valid = '0;
      tick; tick; strobe("rr2_p2", 2, 3'd1, 2'b00, 4'd10);
      tick; quiet("rr2_gap"); tick; quiet("rr2_gap");
      tick; strobe("rr2_p3", 3, 3'd1, 2'b00, 4'd11);
      tick; quiet("rr2_gap"); tick; quiet("rr2_gap");
      tick; strobe("rr2_p0", 0, 3'd1, 2'b00, 4'd8);
      tick; quiet("rr2_gap"); tick; quiet("rr2_gap");
      tick; strobe("rr2_p1", 1, 3'd1, 2'b00, 4'd9);
      tick;

      // Overwrite: port 0 pulses twice while port 2 is being served.
      set_req(2, MAC_LOCAL2, 4'h5);
      tick; i_check_valid = '0; set_req(0, MAC_LOCAL2, 4'h6);
      tick; i_check_valid = '0; set_req(0, MAC_LOCAL2, 4'h7);
      tick; i_check_valid = '0;
      strobe("ovwr_p2", 2, 3'd1, 2'b00, 4'h5);
      tick; quiet("ovwr_n4");
      tick; quiet("ovwr_n5");
      tick; strobe("ovwr_p0", 0, 3'd1, 2'b00, 4'h7);
      tick; quiet("ovwr_n7");
      chk("ovwr_cnt", 64'(o_stat_ovwr_cnt), STAT ? 64'd1 : 64'd0);

      // Pulse on port 0 in the very cycle it is granted.
      set_req(0, MAC_LOCAL2, 4'hB);
      tick; i_check_valid = '0; set_req(0, 48'h8DBC5C4A_05_01, 4'hC);
      tick; i_check_valid = '0;
      tick; strobe("coll_first", 0, 3'd1, 2'b00, 4'hB);
      tick; quiet("coll_n4");
      tick; quiet("coll_n5");
      tick; strobe("coll_second", 0, 3'd5, 2'b10, 4'hC);
      tick; quiet("coll_n7");
      chk("lookup_cnt", 64'(o_stat_lookup_cnt), STAT ? 64'(exp_lk) : 64'd0);

      // Reset while a lookup is in RESOLVE.
      set_req(1, MAC_LOCAL2, 4'h3);
      tick; i_check_valid = '0;
      tick; i_rst = 1'b1; #1;
      exp_lk = 0;
      chk("mrst_valid", 64'(o_result_valid), 64'd0);
      chk("mrst_id", 64'(o_check_id), 64'd0);
      chk("mrst_flag", 64'(o_seek_flag), 64'd0);
      chk("mrst_lookup", 64'(o_stat_lookup_cnt), 64'd0);
      tick; i_rst = 1'b0;
      quiet("mrst_n3");
      for (int k = 0; k < 4; k++) begin
         tick; quiet("mrst_idle");
      end
      i_cur_connect_tor = 3'd3;
      set_req(2, 48'h8DBC5C4A_05_01, 4'h9);
      tick; i_check_valid = '0;
      quiet("post_n1");
      tick; quiet("post_n2");
      tick; strobe("post_rst", 2, 3'd5, 2'b10, 4'h9);
      tick; quiet("post_n4");
      chk("post_lookup", 64'(o_stat_lookup_cnt), STAT ? 64'(exp_lk) : 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
